// File: rtl/uart_message_parse.sv
// uart_message_parse
//   Receive-side frame parser for the host UART link. Hunts for the header
//   0xAF 0xFA, then reads LEN, LEN payload bytes (cmd + args) and an 8-bit
//   checksum (sum of LEN and payload, header excluded). It latches good
//   frames and raises one-cycle status pulses for good and bad frames.
//
//   Optional feature macro: UART_PARSE_TIMEOUT_EN
//     defined   -> inter-byte timeout counter and timeout_err are built
//     undefined -> no counter, timeout_err stays 0, mid-frame wait is unbounded
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   recv_done    in   UART receiver byte-done strobe (level, >=1 cycle)
//   recv_data    in   received byte, stable while recv_done is high
//   frame_valid  out  one-cycle pulse, good frame latched
//   frame_cmd    out  payload byte 0
//   frame_data   out  payload bytes 1..LEN-1, right-aligned, big-endian
//   frame_cnt    out  count of good frames, wraps 255->0
//   chk_err      out  one-cycle pulse, checksum mismatch
//   len_err      out  one-cycle pulse, LEN out of range
//   timeout_err  out  one-cycle pulse, inter-byte timeout
module uart_message_parse #(
  parameter int MAX_LEN     = 4,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       recv_done,
  input  logic [7:0]                 recv_data,
  output logic                       frame_valid,
  output logic [7:0]                 frame_cmd,
  output logic [8*(MAX_LEN-1)-1:0]   frame_data,
  output logic [7:0]                 frame_cnt,
  output logic                       chk_err,
  output logic                       len_err,
  output logic                       timeout_err
);

  localparam int DW = 8*(MAX_LEN-1);

  typedef enum logic [2:0] {
    IDLE,
    HDR2,
    LEN,
    PAYLOAD,
    CHK
  } state_t;

  state_t          state;
  logic            done_d0;
  logic            done_d1;
  logic            rx_flag;
  logic [7:0]      len_q;
  logic [7:0]      sum_q;
  logic [7:0]      idx_q;
  logic [7:0]      cmd_buf;
  logic [DW-1:0]   sr;
  logic            timeout_hit;

  // Two-stage register of the strobe; the rising edge gives exactly one
  // rx_flag per recv_done assertion, however long recv_done is held.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_d0 <= 1'b0;
      done_d1 <= 1'b0;
    end else begin
      done_d0 <= recv_done;
      done_d1 <= done_d0;
    end
  end

  assign rx_flag = done_d0 & ~done_d1;

`ifdef UART_PARSE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] to_cnt;

  // A byte landing on the expiry cycle takes precedence, so the hit is
  // qualified with ~rx_flag.
  assign timeout_hit = !rx_flag && (state != IDLE) &&
                       (to_cnt == CW'(TIMEOUT_CYC - 1));

  // Inter-byte idle counter: only runs while a frame is in progress.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt <= '0;
    end else if (rx_flag || (state == IDLE) || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame parser. Pulses default low every cycle, so at most one fires per
  // cycle; the received byte is always consumed regardless of state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      cmd_buf     <= '0;
      sr          <= '0;
      frame_valid <= 1'b0;
      frame_cmd   <= '0;
      frame_data  <= '0;
      frame_cnt   <= '0;
      chk_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      if (rx_flag) begin
        case (state)
          IDLE: begin
            if (recv_data == 8'hAF) state <= HDR2;
          end
          HDR2: begin
            if (recv_data == 8'hFA)      state <= LEN;
            else if (recv_data == 8'hAF) state <= HDR2;
            else                         state <= IDLE;
          end
          LEN: begin
            if ((recv_data != 8'd0) && (recv_data <= 8'(MAX_LEN))) begin
              len_q <= recv_data;
              sum_q <= recv_data;
              idx_q <= 8'd0;
              sr    <= '0;
              state <= PAYLOAD;
            end else begin
              len_err <= 1'b1;
              state   <= IDLE;
            end
          end
          PAYLOAD: begin
            if (idx_q == 8'd0) cmd_buf <= recv_data;
            else               sr      <= (sr << 8) | DW'(recv_data);
            sum_q <= sum_q + recv_data;
            idx_q <= idx_q + 8'd1;
            if (idx_q == (len_q - 8'd1)) state <= CHK;
          end
          CHK: begin
            if (recv_data == sum_q) begin
              frame_valid <= 1'b1;
              frame_cmd   <= cmd_buf;
              frame_data  <= sr;
              frame_cnt   <= frame_cnt + 8'd1;
            end else begin
              chk_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
        state       <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_message_parse.sv
// tb_uart_message_parse
//   Directed bench for uart_message_parse. Expected events are pushed to a
//   scoreboard queue before the deciding byte is sent; a monitor pops and
//   compares them whenever the parser raises a status pulse. The timeout
//   scenarios are only exercised when UART_PARSE_TIMEOUT_EN is defined.
module tb_uart_message_parse;

  typedef enum int {EV_GOOD, EV_CHK, EV_LEN, EV_TIMEOUT} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  cmd;
    logic [23:0] data;
    logic [7:0]  cnt;
  } ev_t;

  typedef logic [7:0] byte_q_t[$];

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        recv_done;
  logic [7:0]  recv_data;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [23:0] frame_data;
  logic [7:0]  frame_cnt;
  logic        chk_err;
  logic        len_err;
  logic        timeout_err;

  ev_t         sb[$];
  ev_t         mon_ev;
  int          n_asserts = 0;
  int          n_fail    = 0;
  int          cyc       = 0;
  int          rise_cyc  = 0;
  int          mon_npulse;
  int          mon_kind;
  logic [7:0]  held_cmd;
  logic [23:0] held_data;
  logic [7:0]  exp_cnt;

  uart_message_parse #(
    .MAX_LEN     (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .recv_done   (recv_done),
    .recv_data   (recv_data),
    .frame_valid (frame_valid),
    .frame_cmd   (frame_cmd),
    .frame_data  (frame_data),
    .frame_cnt   (frame_cnt),
    .chk_err     (chk_err),
    .len_err     (len_err),
    .timeout_err (timeout_err)
  );

  // 10 ns clock plus an edge counter used to measure pulse latency.
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Single comparison point: every check in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One byte: recv_done held for two cycles, then low for 'gap' cycles.
  // Consecutive calls place rising edges 3+gap cycles apart.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(negedge sys_clk);
    recv_data = b;
    recv_done = 1'b1;
    rise_cyc  = cyc;
    repeat (2) @(negedge sys_clk);
    recv_done = 1'b0;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic sendBytes(input byte_q_t bytes);
    foreach (bytes[i]) applyStimulus(bytes[i], 2);
  endtask

  // Scoreboard pushes; non-good events carry the currently held outputs.
  task automatic expectGood(input logic [7:0] cmd, input logic [23:0] data);
    exp_cnt   = exp_cnt + 8'd1;
    held_cmd  = cmd;
    held_data = data;
    sb.push_back('{EV_GOOD, cmd, data, exp_cnt});
  endtask

  task automatic expectBad(input ev_kind_t kind);
    sb.push_back('{kind, held_cmd, held_data, exp_cnt});
  endtask

  // Bounded wait for the scoreboard to empty, then a few quiet cycles.
  task automatic waitDrain(input int budget);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge sys_clk);
      i++;
    end
    repeat (3) @(negedge sys_clk);
    checkOutput("drain", sb.size(), 0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_frame_valid", frame_valid, 0);
    checkOutput("rst_frame_cmd", frame_cmd, 0);
    checkOutput("rst_frame_data", frame_data, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_chk_err", chk_err, 0);
    checkOutput("rst_len_err", len_err, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
  endtask

  // Monitor: on any status pulse, pop the next expected event and compare
  // kind, latency from recv_done rising, and the held frame outputs.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      mon_npulse = int'(frame_valid) + int'(chk_err) + int'(len_err) + int'(timeout_err);
      if (mon_npulse != 0) begin
        checkOutput("pulse_onehot", mon_npulse, 1);
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse",
                      {28'd0, frame_valid, chk_err, len_err, timeout_err}, 0);
        end else begin
          mon_ev = sb.pop_front();
          mon_kind = frame_valid ? EV_GOOD : chk_err ? EV_CHK :
                     len_err ? EV_LEN : EV_TIMEOUT;
          checkOutput("event_kind", mon_kind, int'(mon_ev.kind));
          if (!timeout_err) checkOutput("pulse_latency", cyc - rise_cyc, 2);
          checkOutput("frame_cmd", frame_cmd, mon_ev.cmd);
          checkOutput("frame_data", frame_data, mon_ev.data);
          checkOutput("frame_cnt", frame_cnt, mon_ev.cnt);
        end
      end
    end
  end

  // Watchdog so a stuck run still ends with a reported failure.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of scenarios.
  initial begin
    sys_rst_n = 1'b0;
    recv_done = 1'b0;
    recv_data = 8'h00;
    held_cmd  = 8'h00;
    held_data = 24'h0;
    exp_cnt   = 8'h00;
    repeat (3) @(negedge sys_clk);
    checkResetOutputs();
    sys_rst_n = 1'b1;

    $display("[TB] good frame");
    expectGood(8'h01, 24'h123456);
    sendBytes('{8'hAF, 8'hFA, 8'h04, 8'h01, 8'h12, 8'h34, 8'h56, 8'hA1});
    waitDrain(50);

    $display("[TB] bad checksum");
    expectBad(EV_CHK);
    sendBytes('{8'hAF, 8'hFA, 8'h04, 8'h01, 8'h12, 8'h34, 8'h56, 8'hA2});
    waitDrain(50);

    $display("[TB] length errors and minimum length");
    expectBad(EV_LEN);
    sendBytes('{8'hAF, 8'hFA, 8'h00});
    waitDrain(50);
    expectBad(EV_LEN);
    sendBytes('{8'hAF, 8'hFA, 8'h05});
    waitDrain(50);
    expectGood(8'h10, 24'h000000);
    sendBytes('{8'hAF, 8'hFA, 8'h01, 8'h10, 8'h11});
    waitDrain(50);

    $display("[TB] resync");
    expectGood(8'h07, 24'h000009);
    sendBytes('{8'h00, 8'hAF, 8'hAF, 8'hFA, 8'h02, 8'h07, 8'h09, 8'h12});
    waitDrain(50);

`ifdef UART_PARSE_TIMEOUT_EN
    $display("[TB] timeout");
    expectBad(EV_TIMEOUT);
    sendBytes('{8'hAF, 8'hFA, 8'h04, 8'h01});
    waitDrain(300);
    expectGood(8'h01, 24'h123456);
    sendBytes('{8'hAF, 8'hFA, 8'h04, 8'h01, 8'h12, 8'h34, 8'h56, 8'hA1});
    waitDrain(50);

    // Next byte's rx_flag lands exactly on the expiry cycle: no timeout.
    expectGood(8'h01, 24'h123456);
    sendBytes('{8'hAF, 8'hFA, 8'h04});
    applyStimulus(8'h01, 97);
    sendBytes('{8'h12, 8'h34, 8'h56, 8'hA1});
    waitDrain(50);

    // One cycle later the timeout fires and the late byte is ignored.
    expectBad(EV_TIMEOUT);
    sendBytes('{8'hAF, 8'hFA, 8'h04});
    applyStimulus(8'h01, 98);
    applyStimulus(8'h12, 2);
    waitDrain(300);
    expectGood(8'h01, 24'h123456);
    sendBytes('{8'hAF, 8'hFA, 8'h04, 8'h01, 8'h12, 8'h34, 8'h56, 8'hA1});
    waitDrain(50);
`endif

    $display("[TB] reset mid-frame");
    sendBytes('{8'hAF, 8'hFA, 8'h04, 8'h01});
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    held_cmd  = 8'h00;
    held_data = 24'h0;
    exp_cnt   = 8'h00;
    #1;
    checkResetOutputs();
    repeat (3) begin
      @(negedge sys_clk);
      checkResetOutputs();
    end
    sys_rst_n = 1'b1;
    expectGood(8'h01, 24'h123456);
    sendBytes('{8'hAF, 8'hFA, 8'h04, 8'h01, 8'h12, 8'h34, 8'h56, 8'hA1});
    waitDrain(50);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_message_parse.md
Name: uart_message_parse

Overview:
Receive-side frame parser for the host UART link; the counterpart of the periodic status uploader.
- Consumes bytes from the UART receiver (recv_done/recv_data).
- Hunts for header 0xAF 0xFA, then reads length, payload and checksum.
- Presents a validated command plus argument bytes to the control logic, with one-cycle status pulses for good and bad frames.

Parameters:
MAX_LEN, 4, maximum payload bytes (cmd + args); legal LEN range 1..MAX_LEN
TIMEOUT_CYC, 5_000_000, inter-byte timeout in sys_clk cycles (100 ms at 50 MHz)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
recv_done  in  1  UART receiver byte-done strobe (level, ≥1 cycle)
recv_data  in  8  received byte, stable while recv_done high
frame_valid  out  1  one-cycle pulse: good frame latched
frame_cmd  out  8  payload byte 0
frame_data  out  8*(MAX_LEN-1)  payload bytes 1..LEN-1, right-aligned, big-endian, unused upper bytes 0
frame_cnt  out  8  count of good frames, wraps 255->0
chk_err  out  1  one-cycle pulse: checksum mismatch
len_err  out  1  one-cycle pulse: LEN out of range
timeout_err  out  1  one-cycle pulse: inter-byte timeout

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk.
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- Byte strobe: recv_done registered twice (d0, d1); rx_flag = d0 & ~d1.
  - rx_flag is high one cycle after recv_done rises.
  - recv_data is sampled while rx_flag is high.
  - Only one rx_flag per recv_done assertion.
- FSM acts only on rx_flag, except for timeout.
  - IDLE: byte 0xAF -> HDR2; otherwise stay.
  - HDR2: 0xFA -> LEN; 0xAF -> stay HDR2 (resync); other -> IDLE.
  - LEN: 1..MAX_LEN -> store len, sum = byte, idx = 0, clear shift register, -> PAYLOAD. 0 or >MAX_LEN -> len_err pulse, -> IDLE.
  - PAYLOAD:
    - idx 0 -> cmd_buf.
    - idx ≥1 -> shift register = (sr << 8) | byte.
    - sum += byte (mod 256); idx++.
    - After byte LEN-1 -> CHK.
  - CHK: byte == sum -> frame_valid pulse, frame_cmd <= cmd_buf, frame_data <= sr, frame_cnt++. Mismatch -> chk_err pulse, outputs unchanged. Either way -> IDLE.
- Latency: frame_valid, chk_err and len_err assert the cycle after the rx_flag of the deciding byte, i.e. two cycles after recv_done rises.
- frame_cmd/frame_data hold until the next good frame and are updated in the same cycle frame_valid asserts.
- Checksum: 8-bit sum of LEN and all payload bytes, header excluded.
- Timeout (when compiled in):
  - Counter clears on every rx_flag and while in IDLE.
  - Otherwise it increments; at TIMEOUT_CYC-1 the FSM goes to IDLE with a timeout_err pulse.
  - If rx_flag arrives in the same cycle, rx_flag wins: the byte is processed, the counter clears, no timeout.
- Pulses never overlap; at most one of frame_valid/chk_err/len_err/timeout_err per cycle.
- Reset mid-frame: immediate return to IDLE; partial frame discarded; no pulses.
- No back-pressure: a byte arriving in any state is always consumed.

Optional Feature:
UART_PARSE_TIMEOUT_EN
- Defined: the inter-byte timeout counter and timeout_err operate as above.
- Undefined: no counter is built, timeout_err is tied 0, and the FSM waits indefinitely mid-frame.

Test Plan:
1. Good frame: bytes AF FA 04 01 12 34 56 A1 -> frame_valid pulse; frame_cmd=0x01, frame_data=0x123456, frame_cnt=1.
2. Bad checksum: AF FA 04 01 12 34 56 A2 -> chk_err pulse, no frame_valid; frame_cmd/frame_data keep their previous values.
3. Length errors: AF FA 00 and AF FA 05 -> len_err each time. Then AF FA 01 10 11 -> frame_valid, frame_cmd=0x10, frame_data=0x000000.
4. Resync: 00 AF AF FA 02 07 09 12 -> frame_valid, frame_cmd=0x07, frame_data=0x000009.
5. Timeout (macro defined, TIMEOUT_CYC=100 in sim): AF FA 04 01, then idle 100 cycles -> timeout_err pulse. Next full frame from test 1 parses correctly. Also: a byte arriving exactly at the timeout cycle suppresses timeout_err.
6. Reset mid-frame: AF FA 04 01, assert sys_rst_n low for 3 cycles, release, send test 1 frame -> all outputs 0 during reset, then frame_valid with frame_cnt=1.
